// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Synchronises the raw PLL lock flag, holds a downstream
//               active-low reset until lock has been continuously stable,
//               enforces a minimum re-reset window after lock loss and
//               keeps a saturating lock-loss event counter for debug.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       locked,
    input  logic       clear_count,
    output logic       sys_resetn,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] lock_lost_count
);

    // One counter serves both the STABLE and HOLD windows, so it is sized
    // for whichever of the two is longer.
    localparam int C_MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

    localparam logic [C_CNT_W-1:0] C_STABLE_LAST = C_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST   = C_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE     = C_CNT_W'(1);
    localparam logic [7:0]         C_COUNT_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_RUN       = 2'd2,
        S_HOLD      = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [C_CNT_W-1:0]     r_cnt;
    logic [C_CNT_W-1:0]     w_cnt_nxt;
    logic                   w_loss_event;

    logic                   r_sys_resetn;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic [7:0]             r_count;
    logic [7:0]             w_count_nxt;

    // Multi-flop synchroniser for the asynchronous lock flag; stage 0 captures first.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Next-state and shared-counter logic; HOLD deliberately ignores lock so
    // the re-reset window always runs to completion.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_loss_event = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt  = S_HOLD;
                    w_cnt_nxt    = '0;
                    w_loss_event = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == C_HOLD_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Saturating event counter; a clear in the same cycle as an event still keeps that event.
    always_comb begin
        w_count_nxt = r_count;
        if (clear_count) begin
            w_count_nxt = w_loss_event ? 8'd1 : 8'd0;
        end else if (w_loss_event && (r_count != C_COUNT_MAX)) begin
            w_count_nxt = r_count + 8'd1;
        end
    end

    // State, counter and outputs share one register stage so reset/ready track the state exactly.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_WAIT_LOCK;
            r_cnt        <= '0;
            r_sys_resetn <= 1'b0;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_count      <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sys_resetn <= (w_state_nxt == S_RUN);
            r_ready      <= (w_state_nxt == S_RUN);
            r_lock_lost  <= w_loss_event;
            r_count      <= w_count_nxt;
        end
    end

    assign sys_resetn      = r_sys_resetn;
    assign ready           = r_ready;
    assign lock_lost       = r_lock_lost;
    assign lock_lost_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Directed self-checking bench for pll_lock_supervisor with
//               SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    logic       clock;
    logic       resetn;
    logic       locked;
    logic       clear_count;
    logic       sys_resetn;
    logic       ready;
    logic       lock_lost;
    logic [7:0] lock_lost_count;

    int checks;
    int errors;
    int exp_cnt;

    pll_lock_supervisor #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4)
    ) u_dut (
        .clock           (clock),
        .resetn          (resetn),
        .locked          (locked),
        .clear_count     (clear_count),
        .sys_resetn      (sys_resetn),
        .ready           (ready),
        .lock_lost       (lock_lost),
        .lock_lost_count (lock_lost_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle lock drop from RUN; optionally clear the counter on the event cycle.
    // Edge j captures the low, HOLD at j+2, WAIT_LOCK at j+6, STABLE at j+7, RUN at j+15.
    task automatic do_loss(input bit clr);
        locked = 1'b0;
        tick();                       // edge j
        locked = 1'b1;
        tick();                       // edge j+1
        chk("loss_pre_sysrst", sys_resetn, 1);
        chk("loss_pre_pulse", lock_lost, 0);
        clear_count = clr;
        tick();                       // edge j+2
        clear_count = 1'b0;
        exp_cnt = clr ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
        chk("loss_pulse", lock_lost, 1);
        chk("loss_sysrst", sys_resetn, 0);
        chk("loss_ready", ready, 0);
        chk("loss_count", lock_lost_count, exp_cnt);
        for (int e = 3; e <= 14; e++) begin
            tick();
            chk("loss_hold_sysrst", sys_resetn, 0);
            chk("loss_hold_pulse", lock_lost, 0);
        end
        tick();                       // edge j+15
        chk("loss_release_sysrst", sys_resetn, 1);
        chk("loss_release_ready", ready, 1);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_cnt     = 0;
        resetn      = 1'b0;
        locked      = 1'b0;
        clear_count = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_sysrst", sys_resetn, 0);
        chk("rst_ready", ready, 0);
        chk("rst_pulse", lock_lost, 0);
        chk("rst_count", lock_lost_count, 0);

        // Power-up lock: raise locked, edge k captures it, release at k+10
        resetn = 1'b1;
        tick();
        chk("wait_sysrst", sys_resetn, 0);
        locked = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();                   // edge k+i
            chk("pwrup_sysrst", sys_resetn, (i == 10) ? 1 : 0);
            chk("pwrup_ready", ready, (i == 10) ? 1 : 0);
        end
        chk("pwrup_count", lock_lost_count, 0);
        chk("pwrup_pulse", lock_lost, 0);

        // Loss in RUN (one-cycle drop)
        do_loss(1'b0);

        // Glitch in STABLE: second loss, then a 2-cycle drop while cnt is 5
        locked = 1'b0;
        tick();                       // edge j
        locked = 1'b1;
        tick();                       // edge j+1
        tick();                       // edge j+2
        exp_cnt = exp_cnt + 1;
        chk("glitch_setup_pulse", lock_lost, 1);
        chk("glitch_setup_count", lock_lost_count, exp_cnt);
        for (int e = 3; e <= 22; e++) begin
            if (e == 11) locked = 1'b0;
            if (e == 13) locked = 1'b1;
            tick();
            chk("glitch_sysrst", sys_resetn, 0);
            chk("glitch_pulse", lock_lost, 0);
        end
        tick();                       // edge j+23: full STABLE restarted after re-lock
        chk("glitch_release", sys_resetn, 1);
        chk("glitch_count", lock_lost_count, exp_cnt);

        // Saturation: 257 more loss events
        for (int n = 0; n < 257; n++) begin
            do_loss(1'b0);
        end
        chk("sat_count", lock_lost_count, 255);

        // Clear alone
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        exp_cnt = 0;
        chk("clear_count", lock_lost_count, 0);
        chk("clear_sysrst", sys_resetn, 1);

        // Clear coincident with a loss event
        do_loss(1'b1);
        chk("clear_event_count", lock_lost_count, 1);

        // Async reset mid-HOLD
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        tick();                       // HOLD entered
        chk("hold_pre_pulse", lock_lost, 1);
        chk("hold_pre_count", lock_lost_count, 2);
        #1 resetn = 1'b0;
        #1;
        chk("arst_hold_sysrst", sys_resetn, 0);
        chk("arst_hold_ready", ready, 0);
        chk("arst_hold_pulse", lock_lost, 0);
        chk("arst_hold_count", lock_lost_count, 0);
        #1 resetn = 1'b1;

        // Relock into mid-STABLE, then async reset again
        for (int i = 0; i <= 4; i++) begin
            tick();
            chk("stable_pre_sysrst", sys_resetn, 0);
        end
        #1 resetn = 1'b0;
        #1;
        chk("arst_stable_sysrst", sys_resetn, 0);
        chk("arst_stable_ready", ready, 0);
        chk("arst_stable_pulse", lock_lost, 0);
        chk("arst_stable_count", lock_lost_count, 0);
        #1 resetn = 1'b1;

        // Full lock sequence must restart from scratch
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk("relock_sysrst", sys_resetn, (i == 10) ? 1 : 0);
            chk("relock_ready", ready, (i == 10) ? 1 : 0);
        end
        chk("relock_count", lock_lost_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
